// File: rtl/univ_shift_pkg.sv
// Shared constants for the universal shift register: mode encodings and
// the supported width range.
package univ_shift_pkg;

  // Mode select encodings applied on the M input
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } shift_mode_e;

  // Supported register widths
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage : univ_shift_pkg

// File: rtl/dff_re_cell.sv
// Single storage bit: positive-edge D flip-flop with asynchronous
// active-high reset and a complementary output.
module dff_re_cell
  import univ_shift_pkg::*;
(
  input  logic D,
  input  logic C,
  input  logic RE,
  output logic Q,
  output logic Qnot
);

  logic r_q;

  // Capture D on the rising edge; RE clears the bit immediately
  always_ff @(posedge C or posedge RE) begin
    if (RE) begin
      r_q <= 1'b0;
    end else begin
      r_q <= D;
    end
  end

  // Qnot is derived from the same flop, so it is ~Q even during reset
  assign Q    = r_q;
  assign Qnot = ~r_q;

endmodule : dff_re_cell

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load,
// with optional rotate. Each bit is a dff_re_cell fed by a gate-level 4:1
// next-state multiplexer. Intended WIDTH range is WIDTH_MIN..WIDTH_MAX.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             C,
  input  logic             RE,
  input  logic [1:0]       M,
  input  logic [WIDTH-1:0] D,
  input  logic             SR,
  input  logic             SL,
  input  logic             RO,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qnot,
  output logic             SO
);

  // Decoded select lines shared by every bit's multiplexer
  logic w_m0;
  logic w_m0_n;
  logic w_m1;
  logic w_m1_n;
  logic w_ro;
  logic w_ro_n;

  assign w_m0   = M[0];
  assign w_m0_n = ~M[0];
  assign w_m1   = M[1];
  assign w_m1_n = ~M[1];
  assign w_ro   = RO;
  assign w_ro_n = ~RO;

  // Serial sources for the edge bits: the vacated bit when rotating,
  // otherwise the external serial input.
  logic w_msb_src;
  logic w_lsb_src;

  assign w_msb_src = (w_ro & Q[0])       | (w_ro_n & SR);
  assign w_lsb_src = (w_ro & Q[WIDTH-1]) | (w_ro_n & SL);

  logic [WIDTH-1:0] w_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic w_right_src;  // value arriving on a shift right
      logic w_left_src;   // value arriving on a shift left
      logic w_lo;         // M[0] selects hold vs shift right
      logic w_hi;         // M[0] selects shift left vs load

      if (gi == WIDTH - 1) begin : g_msb
        assign w_right_src = w_msb_src;
      end else begin : g_mid_r
        assign w_right_src = Q[gi+1];
      end

      if (gi == 0) begin : g_lsb
        assign w_left_src = w_lsb_src;
      end else begin : g_mid_l
        assign w_left_src = Q[gi-1];
      end

      // Two 2:1 levels from AND/OR gates: M[0] picks within a pair, M[1]
      // picks the pair.
      assign w_lo       = (Q[gi] & w_m0_n)      | (w_right_src & w_m0);
      assign w_hi       = (w_left_src & w_m0_n) | (D[gi] & w_m0);
      assign w_next[gi] = (w_lo & w_m1_n)       | (w_hi & w_m1);

      dff_re_cell u_cell (
        .D    (w_next[gi]),
        .C    (C),
        .RE   (RE),
        .Q    (Q[gi]),
        .Qnot (Qnot[gi])
      );
    end
  endgenerate

  // Shift-out shows the bit that the selected shift is about to drop
  assign SO = (M == MODE_SHR) ? Q[0] :
              (M == MODE_SHL) ? Q[WIDTH-1] : 1'b0;

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=4): reset behaviour, a
// vector table of mode operations, mid-sequence reset, and a random run
// against a behavioural model with a scoreboard queue.
module tb_univ_shift_reg;
  import univ_shift_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         re;
  logic [1:0]   m;
  logic [W-1:0] d;
  logic         sr;
  logic         sl;
  logic         ro;
  logic [W-1:0] q;
  logic [W-1:0] qnot;
  logic         so;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] sb_q[$];
  logic [W-1:0] model_q;

  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] d;
    logic         sr;
    logic         sl;
    logic         ro;
    logic [W-1:0] exp_q;
    logic         exp_so;
  } vec_t;

  vec_t vecs[18];

  univ_shift_reg #(.WIDTH(W)) dut (
    .C    (clk),
    .RE   (re),
    .M    (m),
    .D    (d),
    .SR   (sr),
    .SL   (sl),
    .RO   (ro),
    .Q    (q),
    .Qnot (qnot),
    .SO   (so)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Qnot must be the complement of Q at every sample point
  always @(negedge clk) begin
    checks++;
    if (qnot !== ~q) begin
      errors++;
      $display("FAIL qnot_inv: Q=%b Qnot=%b required Qnot=%b", q, qnot, ~q);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] model_next(input logic [W-1:0] cq,
                                              input logic [1:0] cm,
                                              input logic [W-1:0] cd,
                                              input logic csr, input logic csl,
                                              input logic cro);
    case (cm)
      2'b00:   return cq;
      2'b01:   return cro ? {cq[0], cq[W-1:1]} : {csr, cq[W-1:1]};
      2'b10:   return cro ? {cq[W-2:0], cq[W-1]} : {cq[W-2:0], csl};
      default: return cd;
    endcase
  endfunction

  function automatic logic model_so(input logic [W-1:0] cq, input logic [1:0] cm);
    if (cm == 2'b01) return cq[0];
    if (cm == 2'b10) return cq[W-1];
    return 1'b0;
  endfunction

  task automatic check_val(input string name, input logic [W-1:0] act,
                           input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got=%b required=%b", name, act, req);
    end
  endtask

  // One transaction: drive inputs, check SO before the edge, queue the
  // expected Q, clock once, pop and compare.
  task automatic step(input string name, input logic [1:0] tm,
                      input logic [W-1:0] td, input logic tsr,
                      input logic tsl, input logic tro,
                      input logic [W-1:0] exp_q, input logic exp_so);
    logic [W-1:0] e;
    m  = tm;
    d  = td;
    sr = tsr;
    sl = tsl;
    ro = tro;
    #1;
    checks++;
    if (so !== exp_so) begin
      errors++;
      $display("FAIL %s_so: got=%b required=%b", name, so, exp_so);
    end
    sb_q.push_back(exp_q);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check_val({name, "_q"}, q, e);
      check_val({name, "_qnot"}, qnot, ~e);
    end
    $display("txn %s M=%b D=%b SR=%b SL=%b RO=%b -> Q=%b", name, tm, td, tsr, tsl, tro, q);
  endtask

  initial begin
    re = 1'b0; m = 2'b00; d = '0; sr = 1'b0; sl = 1'b0; ro = 1'b0;

    // Reset pulse with no clock edge: outputs clear at once
    #2 re = 1'b1;
    #1;
    check_val("reset_q", q, 4'b0000);
    check_val("reset_qnot", qnot, 4'b1111);

    // A clock edge while held in reset does nothing
    m = MODE_LOAD; d = 4'b1111;
    @(posedge clk);
    #1;
    check_val("reset_edge_q", q, 4'b0000);
    check_val("reset_edge_qnot", qnot, 4'b1111);
    re = 1'b0;

    // First edge after release operates on the all-zero state
    step("post_reset_shr", MODE_SHR, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0);

    // Mode vector table (runs from Q=1000)
    vecs[0]  = '{MODE_LOAD, 4'b1011, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b0};
    vecs[1]  = '{MODE_HOLD, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b1011, 1'b0};
    vecs[2]  = '{MODE_HOLD, 4'b0101, 1'b0, 1'b1, 1'b0, 4'b1011, 1'b0};
    vecs[3]  = '{MODE_HOLD, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b1011, 1'b0};
    vecs[4]  = '{MODE_SHR,  4'b0000, 1'b1, 1'b0, 1'b0, 4'b1101, 1'b1};
    vecs[5]  = '{MODE_SHR,  4'b0000, 1'b1, 1'b0, 1'b0, 4'b1110, 1'b1};
    vecs[6]  = '{MODE_LOAD, 4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0};
    vecs[7]  = '{MODE_SHL,  4'b0000, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1};
    vecs[8]  = '{MODE_SHL,  4'b0000, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0};
    vecs[9]  = '{MODE_SHL,  4'b0000, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0};
    vecs[10] = '{MODE_SHL,  4'b0000, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0};
    vecs[11] = '{MODE_SHR,  4'b0000, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0};
    vecs[12] = '{MODE_SHR,  4'b0000, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b0};
    vecs[13] = '{MODE_LOAD, 4'b0110, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0};
    vecs[14] = '{MODE_SHL,  4'b0000, 1'b0, 1'b1, 1'b0, 4'b1101, 1'b0};
    vecs[15] = '{MODE_SHL,  4'b0000, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b1};
    vecs[16] = '{MODE_SHR,  4'b0000, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b0};
    vecs[17] = '{MODE_SHR,  4'b0000, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b1};

    for (int i = 0; i < 18; i++) begin
      step($sformatf("vec%0d", i), vecs[i].m, vecs[i].d, vecs[i].sr,
           vecs[i].sl, vecs[i].ro, vecs[i].exp_q, vecs[i].exp_so);
    end

    // Asynchronous reset in the middle of a shift sequence
    step("mid_load", MODE_LOAD, 4'b0110, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0);
    step("mid_shr",  MODE_SHR,  4'b0000, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b0);
    #2 re = 1'b1;
    #1;
    check_val("mid_reset_q", q, 4'b0000);
    check_val("mid_reset_qnot", qnot, 4'b1111);
    #1 re = 1'b0;
    step("after_mid_load", MODE_LOAD, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b0);

    // Random run against the behavioural model
    model_q = 4'b0101;
    for (int i = 0; i < 1000; i++) begin
      logic [1:0]   rm;
      logic [W-1:0] rd;
      logic         rsr, rsl, rro;
      logic [W-1:0] nq;
      rm  = 2'($urandom_range(0, 3));
      rd  = W'($urandom);
      rsr = 1'($urandom);
      rsl = 1'($urandom);
      rro = 1'($urandom);
      nq  = model_next(model_q, rm, rd, rsr, rsl, rro);
      step($sformatf("rand%0d", i), rm, rd, rsr, rsl, rro, nq, model_so(model_q, rm));
      model_q = nq;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_univ_shift_reg
